// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: entry layout, drain FSM states,
// default depth and the word-address compare used by load conflict checks.
package store_buffer_pkg;

    // Default number of pending-store entries (power of two, >= 2).
    localparam int unsigned SB_DEPTH_DEFAULT = 4;

    // One pending store as held in the circular FIFO.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        valid;
    } type_sb_entry_s;

    // Drain state machine: IDLE has nothing to send, DRAIN offers the head entry.
    typedef enum logic [0:0] {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } type_sb_states_e;

    // Two addresses hit the same 32-bit word when bits [31:2] agree.
    function automatic logic same_word(input logic [29:0] a_word, input logic [29:0] b_word);
        return (a_word == b_word);
    endfunction

endpackage

// File: rtl/store_buffer.sv
// Store buffer: queues committed stores from the LSU in order and drains them
// one at a time to the data cache. Loads that touch a word still pending in
// the buffer are flagged so the LSU can hold them until the store retires.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned SB_DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_st_req,
    input  logic [31:0] lsu_st_addr,
    input  logic [31:0] lsu_st_data,
    input  logic [3:0]  lsu_st_sel,
    output logic        sb_stall,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    input  logic        fence_req,
    output logic        sb_empty,
    output logic        dcache_req,
    output logic [31:0] dcache_addr,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_sel,
    input  logic        dcache_ack
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SB_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    type_sb_entry_s  entries_q [SB_DEPTH];
    type_sb_entry_s  entries_d [SB_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    type_sb_states_e  state_q, state_d;

    logic             full_s;
    logic             stall_s;
    logic             push_s;
    logic             pop_s;
    logic             dcache_req_s;
    logic             conflict_s;
    type_sb_entry_s   head_s;
    logic             unused_ld_offset_s;

    // Byte offset of the load never matters: conflicts are checked per word.
    assign unused_ld_offset_s = ^ld_addr[1:0];

    assign full_s       = (count_q == FULL_CNT);
    // A pop in the same cycle does not free a slot for the incoming store.
    assign stall_s      = lsu_st_req & (full_s | fence_req);
    assign push_s       = lsu_st_req & ~stall_s;
    assign dcache_req_s = (state_q == SB_DRAIN);
    // Acks are only meaningful while a write is being offered.
    assign pop_s        = dcache_req_s & dcache_ack;
    assign head_s       = entries_q[rd_ptr_q];

    // Entry array next state: write the new store at the tail, retire the head.
    always_comb begin
        entries_d = entries_q;
        if (push_s) begin
            entries_d[wr_ptr_q] = '{addr: lsu_st_addr, data: lsu_st_data,
                                    sel: lsu_st_sel, valid: 1'b1};
        end else begin
            entries_d[wr_ptr_q] = entries_q[wr_ptr_q];
        end
        // Head and tail slots never coincide when both a push and a pop happen,
        // because a push needs a free slot and a pop needs a filled one.
        if (pop_s) begin
            entries_d[rd_ptr_q].valid = 1'b0;
        end else begin
            entries_d[rd_ptr_q].valid = entries_d[rd_ptr_q].valid;
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at SB_DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    // Drain FSM: leave DRAIN only when the last entry retires with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_IDLE: begin
                if (count_q != ZERO_CNT) begin
                    state_d = SB_DRAIN;
                end else begin
                    state_d = SB_IDLE;
                end
            end
            SB_DRAIN: begin
                if (pop_s && (count_q == ONE_CNT) && !push_s) begin
                    state_d = SB_IDLE;
                end else begin
                    state_d = SB_DRAIN;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    // Load conflict: any valid entry, including the head in flight, on the same word.
    always_comb begin
        conflict_s = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            conflict_s = conflict_s |
                         (entries_q[i].valid & same_word(entries_q[i].addr[31:2], ld_addr[31:2]));
        end
    end

    // Cache write fields come straight from the head entry while a write is offered.
    always_comb begin
        dcache_addr  = 32'h0000_0000;
        dcache_wdata = 32'h0000_0000;
        dcache_sel   = 4'h0;
        if (dcache_req_s) begin
            dcache_addr  = head_s.addr;
            dcache_wdata = head_s.data;
            dcache_sel   = head_s.sel;
        end else begin
            dcache_addr  = 32'h0000_0000;
            dcache_wdata = 32'h0000_0000;
            dcache_sel   = 4'h0;
        end
    end

    // State registers; reset abandons any in-flight write and empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries_q <= '{default: '0};
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= SB_IDLE;
        end else begin
            entries_q <= entries_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    assign sb_stall    = stall_s;
    assign ld_conflict = conflict_s;
    assign sb_empty    = (count_q == ZERO_CNT);
    assign dcache_req  = dcache_req_s;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference of pending stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_st_req = 1'b0;
    logic [31:0] lsu_st_addr = 32'h0;
    logic [31:0] lsu_st_data = 32'h0;
    logic [3:0]  lsu_st_sel = 4'h0;
    logic        sb_stall;
    logic [31:0] ld_addr = 32'h0;
    logic        ld_conflict;
    logic        fence_req = 1'b0;
    logic        sb_empty;
    logic        dcache_req;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [3:0]  dcache_sel;
    logic        dcache_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference: stores accepted but not yet written to the cache, in order.
    st_t exp_q[$];
    int  prev_cnt = 0;

    store_buffer #(.SB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_st_req(lsu_st_req), .lsu_st_addr(lsu_st_addr),
        .lsu_st_data(lsu_st_data), .lsu_st_sel(lsu_st_sel),
        .sb_stall(sb_stall), .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .fence_req(fence_req), .sb_empty(sb_empty),
        .dcache_req(dcache_req), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_sel(dcache_sel),
        .dcache_ack(dcache_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step: compare all outputs, then apply this cycle's push/pop.
    task automatic monitor_step();
        int   cnt;
        logic e_req, e_stall, e_conf;
        st_t  n;
        if (!rst_n) begin
            chk("rst_dcache_req", {31'h0, dcache_req}, 32'h0);
            chk("rst_dcache_addr", dcache_addr, 32'h0);
            chk("rst_dcache_wdata", dcache_wdata, 32'h0);
            chk("rst_dcache_sel", {28'h0, dcache_sel}, 32'h0);
            chk("rst_sb_stall", {31'h0, sb_stall}, 32'h0);
            chk("rst_ld_conflict", {31'h0, ld_conflict}, 32'h0);
            chk("rst_sb_empty", {31'h0, sb_empty}, 32'h1);
            exp_q.delete();
            prev_cnt = 0;
        end else begin
            cnt = exp_q.size();
            // A write is offered once the buffer has been non-empty a full cycle.
            e_req   = (prev_cnt != 0) && (cnt != 0);
            e_stall = lsu_st_req && ((cnt == DEPTH) || fence_req);
            e_conf  = 1'b0;
            foreach (exp_q[i]) begin
                if (exp_q[i].a[31:2] == ld_addr[31:2]) e_conf = 1'b1;
            end
            chk("sb_empty", {31'h0, sb_empty}, {31'h0, (cnt == 0)});
            chk("sb_stall", {31'h0, sb_stall}, {31'h0, e_stall});
            chk("ld_conflict", {31'h0, ld_conflict}, {31'h0, e_conf});
            chk("dcache_req", {31'h0, dcache_req}, {31'h0, e_req});
            if (e_req) begin
                chk("dcache_addr", dcache_addr, exp_q[0].a);
                chk("dcache_wdata", dcache_wdata, exp_q[0].d);
                chk("dcache_sel", {28'h0, dcache_sel}, {28'h0, exp_q[0].s});
            end
            prev_cnt = cnt;
            if (e_req && dcache_ack) void'(exp_q.pop_front());
            if (lsu_st_req && !e_stall) begin
                n.a = lsu_st_addr;
                n.d = lsu_st_data;
                n.s = lsu_st_sel;
                exp_q.push_back(n);
            end
        end
    endtask

    always @(negedge clk) monitor_step();

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        lsu_st_req  = 1'b1;
        lsu_st_addr = a;
        lsu_st_data = d;
        lsu_st_sel  = s;
    endtask

    task automatic quiet();
        lsu_st_req = 1'b0;
        fence_req  = 1'b0;
        dcache_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] wsel;
        logic [3:0] widx;
        logic [1:0] woff;

        cyc(3);
        rst_n = 1'b1;
        cyc(1);

        // Single store, acked on its third request cycle.
        st(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
        cyc(1);
        lsu_st_req = 1'b0;
        chk("s1_idle_req", {31'h0, dcache_req}, 32'h0);
        chk("s1_not_empty", {31'h0, sb_empty}, 32'h0);
        cyc(1);
        chk("s1_req_c1", {31'h0, dcache_req}, 32'h1);
        chk("s1_addr", dcache_addr, 32'h8000_0010);
        cyc(2);
        dcache_ack = 1'b1;
        cyc(1);
        dcache_ack = 1'b0;
        chk("s1_empty_after_ack", {31'h0, sb_empty}, 32'h1);
        chk("s1_req_dropped", {31'h0, dcache_req}, 32'h0);
        cyc(2);

        // Five back-to-back stores with ack low: fifth stalls; drain in order.
        for (int k = 0; k < 5; k++) begin
            st(32'(k * 4), $urandom, 4'hF);
            #1;
            chk("fill_stall", {31'h0, sb_stall}, {31'h0, (k == 4)});
            cyc(1);
        end
        lsu_st_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("fill_drain_addr", dcache_addr, 32'(k * 4));
            dcache_ack = 1'b1;
            cyc(1);
            dcache_ack = 1'b0;
            cyc(1);
        end
        chk("fill_empty", {31'h0, sb_empty}, 32'h1);

        // Load conflict is per word, regardless of byte lane.
        st(32'h0000_0100, 32'h0000_00AA, 4'h1);
        cyc(1);
        lsu_st_req = 1'b0;
        ld_addr = 32'h0000_0102;
        #1;
        chk("conf_same_word", {31'h0, ld_conflict}, 32'h1);
        ld_addr = 32'h0000_0104;
        #1;
        chk("conf_next_word", {31'h0, ld_conflict}, 32'h0);
        dcache_ack = 1'b1;
        cyc(3);
        dcache_ack = 1'b0;
        cyc(1);

        // Fence with three pending stores: new store stalls while buffer drains.
        for (int k = 0; k < 3; k++) begin
            st(32'h0000_0200 + 32'(k * 4), $urandom, 4'h3);
            cyc(1);
        end
        fence_req = 1'b1;
        st(32'h0000_0300, 32'h1234_5678, 4'hF);
        #1;
        chk("fence_stall", {31'h0, sb_stall}, 32'h1);
        dcache_ack = 1'b1;
        cyc(5);
        chk("fence_empty", {31'h0, sb_empty}, 32'h1);
        chk("fence_still_stall", {31'h0, sb_stall}, 32'h1);
        quiet();
        cyc(2);

        // Pointer wrap: nine simultaneous push/pop pairs keep occupancy at two.
        st(32'h0000_0400, $urandom, 4'hF);
        cyc(1);
        st(32'h0000_0404, $urandom, 4'hF);
        cyc(1);
        for (int k = 0; k < 9; k++) begin
            st(32'h0000_0408 + 32'(k * 4), $urandom, 4'(k));
            dcache_ack = 1'b1;
            #1;
            chk("wrap_req", {31'h0, dcache_req}, 32'h1);
            chk("wrap_no_stall", {31'h0, sb_stall}, 32'h0);
            cyc(1);
        end
        lsu_st_req = 1'b0;
        cyc(3);
        dcache_ack = 1'b0;
        chk("wrap_empty", {31'h0, sb_empty}, 32'h1);
        cyc(1);

        // Reset in the middle of a drain with two entries.
        st(32'h0000_0500, $urandom, 4'hF);
        cyc(1);
        st(32'h0000_0504, $urandom, 4'hF);
        cyc(1);
        lsu_st_req = 1'b0;
        chk("rst_pre_req", {31'h0, dcache_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", {31'h0, dcache_req}, 32'h0);
        chk("rst_async_empty", {31'h0, sb_empty}, 32'h1);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Random traffic over a small address pool so conflicts and fills occur.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                quiet();
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
            widx = 4'($urandom_range(0, 15));
            woff = 2'($urandom_range(0, 3));
            wsel = 4'($urandom_range(0, 15));
            lsu_st_req  = ($urandom_range(0, 99) < 60);
            lsu_st_addr = {26'h0, widx, woff};
            lsu_st_data = $urandom;
            lsu_st_sel  = wsel;
            fence_req   = ($urandom_range(0, 9) == 0);
            dcache_ack  = ($urandom_range(0, 99) < 45);
            widx = 4'($urandom_range(0, 15));
            woff = 2'($urandom_range(0, 3));
            ld_addr = {26'h0, widx, woff};
            cyc(1);
        end

        quiet();
        dcache_ack = 1'b1;
        cyc(10);
        dcache_ack = 1'b0;
        chk("final_empty", {31'h0, sb_empty}, 32'h1);
        cyc(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
